sync_fifo_rd_ctrl: RTL and testbench

Read-side controller for the synchronous FIFO storage array. It owns the read pointer and the occupancy count, and drives the array's read address. It captures the array's combinational read data into an output register and presents it as a first-word-fall-through valid/ready stream. The write side drives the array's `we`/`w_addr`/`w_data` and reports each committed write to this block on `push`; this block returns `full` to gate further writes.

---
 rtl/sync_fifo_rd_ctrl_if.sv | 23 ++
 rtl/sync_fifo_rd_ctrl.sv | 88 ++++++++
 tb/tb_sync_fifo_rd_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_rd_ctrl_if.sv
// Output stream of the FIFO read controller: first-word-fall-through
// valid/ready handshake carrying the head-of-FIFO word.
interface sync_fifo_rd_ctrl_if #(
  parameter int D_WIDTH = 8
);
  logic [D_WIDTH-1:0] out_data;
  logic               out_valid;
  logic               out_ready;

  // Producer side (the read controller)
  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  // Consumer side
  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/sync_fifo_rd_ctrl.sv
// Read-side controller for the synchronous FIFO storage array.
// Owns the read pointer and occupancy count, drives the array read address
// and registers the array's combinational read data into a FWFT output stage.
module sync_fifo_rd_ctrl #(
  parameter int DEPTH   = 1024,
  parameter int D_WIDTH = 8,
  parameter int AW      = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  output logic [AW-1:0]        r_addr,
  input  logic [D_WIDTH-1:0]   r_data,
  sync_fifo_rd_ctrl_if.master  out_if,
  output logic                 full,
  output logic                 empty,
  output logic [AW:0]          count,
  output logic                 overflow
);

  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0] rd_ptr;
  logic [AW:0]   mem_cnt;
  logic          load;
  logic          push_ok;
  logic          xfer;

  // Handshake decode and status flags derived from the current state
  always_comb begin
    load    = 1'b0;
    push_ok = 1'b0;
    xfer    = 1'b0;
    full    = 1'b0;
    empty   = 1'b0;
    count   = '0;

    full    = (mem_cnt == DEPTH_CNT);
    // full is evaluated on pre-update state, so a push coinciding with a
    // load from a full array is still rejected
    push_ok = push && !full;
    xfer    = out_if.out_valid && out_if.out_ready;
    load    = (mem_cnt != '0) && (!out_if.out_valid || out_if.out_ready);
    empty   = (mem_cnt == '0) && !out_if.out_valid;
    count   = mem_cnt + (AW+1)'(out_if.out_valid);
  end

  assign r_addr = rd_ptr;

  // Read pointer and output register: load the head word whenever the
  // output stage is empty or being consumed
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr           <= '0;
      out_if.out_data  <= '0;
      out_if.out_valid <= 1'b0;
    end else if (load) begin
      out_if.out_data  <= r_data;
      out_if.out_valid <= 1'b1;
      rd_ptr           <= rd_ptr + 1'b1;
    end else if (xfer) begin
      out_if.out_valid <= 1'b0;
    end
  end

  // Array occupancy: accepted pushes add, loads remove
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_cnt <= '0;
    end else begin
      case ({push_ok, load})
        2'b10:   mem_cnt <= mem_cnt + 1'b1;
        2'b01:   mem_cnt <= mem_cnt - 1'b1;
        default: mem_cnt <= mem_cnt;
      endcase
    end
  end

  // Sticky overflow: a push seen while full is flagged until reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (push && full) begin
      overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sync_fifo_rd_ctrl.sv
// Directed bench for sync_fifo_rd_ctrl with a scoreboard on the output stream.
module tb_sync_fifo_rd_ctrl;

  localparam int DEPTH = 4;
  localparam int DW    = 8;
  localparam int AW    = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          push = 1'b0;
  logic [DW-1:0] w_data = '0;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_data;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          overflow;

  sync_fifo_rd_ctrl_if #(.D_WIDTH(DW)) ifc ();

  sync_fifo_rd_ctrl #(.DEPTH(DEPTH), .D_WIDTH(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .r_addr   (r_addr),
    .r_data   (r_data),
    .out_if   (ifc.master),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Write side of the storage array
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] w_ptr;
  assign r_data = mem[r_addr];

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      w_ptr <= '0;
    end else if (push && !full) begin
      mem[w_ptr] <= w_data;
      w_ptr      <= w_ptr + 1'b1;
    end
  end

  int unsigned   n_chk  = 0;
  int unsigned   n_fail = 0;
  int unsigned   n_xfer = 0;
  logic [DW-1:0] sb [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance into the next cycle; inputs are driven right after this
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Sample point in the middle of the current cycle
  task automatic samp();
    @(negedge clk);
  endtask

  // Monitor: pops the scoreboard on every transfer and checks stall stability
  initial begin
    logic          stall;
    logic [DW-1:0] held;
    logic [DW-1:0] exp;
    stall = 1'b0;
    held  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          check("hold_valid", 32'(ifc.out_valid), 32'd1);
          check("hold_data", 32'(ifc.out_data), 32'(held));
        end
        if (ifc.out_valid && ifc.out_ready) begin
          n_xfer++;
          if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_word: got %0h expected none at %0t", ifc.out_data, $time);
          end else begin
            exp = sb.pop_front();
            check("stream_data", 32'(ifc.out_data), 32'(exp));
          end
        end
        stall = ifc.out_valid && !ifc.out_ready;
        held  = ifc.out_data;
      end
    end
  end

  task automatic drive_push(input logic [DW-1:0] d, input bit accept);
    push   = 1'b1;
    w_data = d;
    if (accept) sb.push_back(d);
  endtask

  // Drain with out_ready high until empty, bounded by a cycle budget
  task automatic drain(input int limit);
    bit done;
    done = 1'b0;
    cyc();
    push = 1'b0;
    ifc.out_ready = 1'b1;
    for (int i = 0; i < limit; i++) begin
      samp();
      if (empty) begin
        done = 1'b1;
        break;
      end
      cyc();
    end
    check("drain_done", 32'(done), 32'd1);
    check("drain_sb_empty", sb.size(), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1);
  end

  initial begin
    int unsigned base;
    logic        rpat [6];
    ifc.out_ready = 1'b0;

    // Reset for cycles 1-2
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    samp();                               // cycle 3
    check("rst_r_addr", 32'(r_addr), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_count", 32'(count), 32'd0);
    check("rst_valid", 32'(ifc.out_valid), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    cyc();                                // cycle 4
    cyc();                                // cycle 5
    drive_push(8'hA5, 1'b1);
    cyc();                                // cycle 6
    push = 1'b0;
    samp();
    check("single_valid_c6", 32'(ifc.out_valid), 32'd0);
    check("single_count_c6", 32'(count), 32'd1);
    cyc();                                // cycle 7
    samp();
    check("single_valid_c7", 32'(ifc.out_valid), 32'd1);
    check("single_data_c7", 32'(ifc.out_data), 32'hA5);
    check("single_count_c7", 32'(count), 32'd1);
    check("single_empty_c7", 32'(empty), 32'd0);
    cyc();                                // cycle 8
    cyc();                                // cycle 9
    ifc.out_ready = 1'b1;
    cyc();                                // cycle 10
    ifc.out_ready = 1'b0;
    samp();
    check("single_empty_c10", 32'(empty), 32'd1);
    check("single_count_c10", 32'(count), 32'd0);

    // Streaming 0x00..0x0F with out_ready held high
    for (int i = 0; i < 16; i++) begin
      cyc();
      ifc.out_ready = 1'b1;
      drive_push(8'(i), 1'b1);
      samp();
      check("stream_count_le3", 32'(count <= 3), 32'd1);
      if (i >= 2) check("stream_valid", 32'(ifc.out_valid), 32'd1);
    end
    cyc();
    push = 1'b0;
    samp();
    check("stream_valid_t16", 32'(ifc.out_valid), 32'd1);
    cyc();
    samp();
    check("stream_valid_t17", 32'(ifc.out_valid), 32'd1);
    cyc();
    samp();
    check("stream_valid_t18", 32'(ifc.out_valid), 32'd0);
    check("stream_sb_empty", sb.size(), 32'd0);

    // Fill and wrap: 1..5 fills array plus output register
    for (int v = 1; v <= 5; v++) begin
      cyc();
      ifc.out_ready = 1'b0;
      drive_push(8'(v), 1'b1);
    end
    cyc();
    push = 1'b0;
    samp();
    check("fill_full", 32'(full), 32'd1);
    check("fill_count", 32'(count), 32'd5);
    check("fill_empty", 32'(empty), 32'd0);
    cyc();
    ifc.out_ready = 1'b1;
    samp();
    check("fill_full_during_load", 32'(full), 32'd1);
    cyc();
    samp();
    check("fill_full_after_load", 32'(full), 32'd0);
    cyc();
    ifc.out_ready = 1'b0;
    samp();
    check("fill_count_drained2", 32'(count), 32'd3);
    cyc();
    drive_push(8'h06, 1'b1);
    cyc();
    drive_push(8'h07, 1'b1);
    cyc();
    push = 1'b0;
    samp();
    check("wrap_full", 32'(full), 32'd1);
    check("wrap_count", 32'(count), 32'd5);
    drain(20);
    check("wrap_overflow", 32'(overflow), 32'd0);

    // Overflow: push while full is rejected and flagged
    for (int v = 0; v < 5; v++) begin
      cyc();
      ifc.out_ready = 1'b0;
      drive_push(8'(8'h11 + v), 1'b1);
    end
    cyc();
    drive_push(8'h99, 1'b0);
    cyc();
    push = 1'b0;
    samp();
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_count", 32'(count), 32'd5);
    check("ovf_full", 32'(full), 32'd1);
    drain(20);
    check("ovf_sticky", 32'(overflow), 32'd1);
    cyc();
    ifc.out_ready = 1'b0;
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    samp();
    check("ovf_cleared", 32'(overflow), 32'd0);

    // Backpressure stall with 3 words queued
    cyc();
    drive_push(8'h21, 1'b1);
    cyc();
    drive_push(8'h22, 1'b1);
    cyc();
    drive_push(8'h23, 1'b1);
    cyc();
    push = 1'b0;
    cyc();
    samp();
    check("bp_count", 32'(count), 32'd3);
    rpat[0] = 1'b0; rpat[1] = 1'b1; rpat[2] = 1'b0;
    rpat[3] = 1'b0; rpat[4] = 1'b1; rpat[5] = 1'b1;
    base = n_xfer;
    for (int i = 0; i < 6; i++) begin
      cyc();
      ifc.out_ready = rpat[i];
    end
    cyc();
    ifc.out_ready = 1'b0;
    samp();
    check("bp_xfers", n_xfer - base, 32'd3);
    check("bp_sb_empty", sb.size(), 32'd0);
    check("bp_empty", 32'(empty), 32'd1);

    // Reset mid-operation discards held words
    cyc();
    drive_push(8'h31, 1'b1);
    cyc();
    drive_push(8'h32, 1'b1);
    cyc();
    drive_push(8'h33, 1'b1);
    cyc();
    push = 1'b0;
    cyc();
    samp();
    check("mid_count", 32'(count), 32'd3);
    check("mid_valid", 32'(ifc.out_valid), 32'd1);
    cyc();
    rst_n = 1'b0;
    sb.delete();
    cyc();
    rst_n = 1'b1;
    samp();
    check("mid_rst_valid", 32'(ifc.out_valid), 32'd0);
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_r_addr", 32'(r_addr), 32'd0);
    check("mid_rst_empty", 32'(empty), 32'd1);
    cyc();
    ifc.out_ready = 1'b1;
    drive_push(8'h3C, 1'b1);
    cyc();
    push = 1'b0;
    samp();
    check("post_rst_valid_n1", 32'(ifc.out_valid), 32'd0);
    cyc();
    samp();
    check("post_rst_valid_n2", 32'(ifc.out_valid), 32'd1);
    check("post_rst_data_n2", 32'(ifc.out_data), 32'h3C);
    cyc();
    samp();
    check("post_rst_empty", 32'(empty), 32'd1);
    check("final_sb_empty", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
